// File: rtl/fpm_pkg.sv
// Shared constants and types for the floating-point multiplier pipeline controller.
// Stage indices name the datapath stages sequenced by the default four-stage build.
package fpm_pkg;

    localparam int unsigned FPM_STAGES = 4;
    localparam int unsigned FPM_TAG_W  = 4;
    localparam int unsigned FPM_CNT_W  = 16;

    localparam int unsigned ST_PPGEN = 0;
    localparam int unsigned ST_RED   = 1;
    localparam int unsigned ST_CPA   = 2;
    localparam int unsigned ST_NORM  = 3;

    typedef logic [FPM_TAG_W-1:0] fpm_tag_t;

endpackage

// File: rtl/fpm_pipe_ctrl_if.sv
// Input and output valid/ready handshakes of the multiplier pipeline.
// The master drives operations in and consumes results; the slave is the controller.
interface fpm_pipe_ctrl_if #(
    parameter int unsigned TAG_W = fpm_pkg::FPM_TAG_W
);

    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag;
    logic             in_special;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic             out_special;

    modport master (
        output in_valid, in_tag, in_special, out_ready,
        input  in_ready, out_valid, out_tag, out_special
    );

    modport slave (
        input  in_valid, in_tag, in_special, out_ready,
        output in_ready, out_valid, out_tag, out_special
    );

endinterface

// File: rtl/fpm_stage_slot.sv
// One pipeline stage's valid/tag/special register. Loads from upstream on its enable,
// empties when its contents move on without a reload, and empties on flush.
module fpm_stage_slot
    import fpm_pkg::*;
#(
    parameter int unsigned TAG_W = FPM_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             adv,
    input  logic             up_valid,
    input  logic [TAG_W-1:0] up_tag,
    input  logic             up_spec,
    output logic             valid,
    output logic [TAG_W-1:0] tag,
    output logic             spec
);

    logic             v_q, v_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             spec_q, spec_d;

    always_comb begin
        // NOTE: every *_d gets its hold value first, so no path can infer a latch.
        v_d    = v_q;
        tag_d  = tag_q;
        spec_d = spec_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (load) begin
            v_d    = up_valid;
            tag_d  = up_tag;
            spec_d = up_spec;
        end else if (adv) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge; non-blocking so every flop sees pre-edge values.
        if (!rst_n) begin
            v_q    <= 1'b0;
            tag_q  <= '0;
            spec_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            tag_q  <= tag_d;
            spec_q <= spec_d;
        end
    end

    assign valid = v_q;
    assign tag   = tag_q;
    assign spec  = spec_q;

endmodule

// File: rtl/fpm_pipe_ctrl.sv
// Elastic pipeline controller for the radix-4 FP multiplier: chains ready backwards,
// drives per-stage load enables, and keeps occupancy and delivery/stall counters.
module fpm_pipe_ctrl
    import fpm_pkg::*;
#(
    parameter  int unsigned STAGES = FPM_STAGES,
    parameter  int unsigned TAG_W  = FPM_TAG_W,
    parameter  int unsigned CNT_W  = FPM_CNT_W,
    localparam int unsigned OCC_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    fpm_pipe_ctrl_if.slave    hs,
    input  logic              flush,
    output logic [STAGES-1:0] stage_en,
    output logic              busy,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  done_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [STAGES-1:0]            v, adv, ld_ok, up_v, spec, up_spec;
    logic [STAGES-1:0][TAG_W-1:0] tag, up_tag;
    logic                         in_ready;
    logic [OCC_W-1:0]             occ_q, occ_d;
    logic [CNT_W-1:0]             done_q, done_d, stall_q, stall_d;

    // Ready chains from the output stage back to stage 0 in a single cycle.
    always_comb begin
        adv   = '0;
        ld_ok = '0;
        adv[STAGES-1]   = v[STAGES-1] & hs.out_ready;
        ld_ok[STAGES-1] = ~v[STAGES-1] | adv[STAGES-1];
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            adv[i]   = v[i] & ld_ok[i+1];
            ld_ok[i] = ~v[i] | adv[i];
        end
    end

    always_comb begin
        stage_en = '0;
        in_ready = ld_ok[ST_PPGEN] & ~flush & rst_n;
        stage_en[ST_PPGEN] = hs.in_valid & in_ready;
        for (int i = 1; i < int'(STAGES); i++) begin
            stage_en[i] = adv[i-1] & ~flush & rst_n;
        end
    end

    always_comb begin
        up_v    = '0;
        up_tag  = '0;
        up_spec = '0;
        up_v[ST_PPGEN]    = hs.in_valid;
        up_tag[ST_PPGEN]  = hs.in_tag;
        up_spec[ST_PPGEN] = hs.in_special;
        for (int i = 1; i < int'(STAGES); i++) begin
            up_v[i]    = v[i-1];
            up_tag[i]  = tag[i-1];
            up_spec[i] = spec[i-1];
        end
    end

    for (genvar g = 0; g < int'(STAGES); g++) begin : g_slot
        fpm_stage_slot #(.TAG_W(TAG_W)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .load     (stage_en[g]),
            .adv      (adv[g]),
            .up_valid (up_v[g]),
            .up_tag   (up_tag[g]),
            .up_spec  (up_spec[g]),
            .valid    (v[g]),
            .tag      (tag[g]),
            .spec     (spec[g])
        );
    end

    // Occupancy tracks v incrementally: +1 on entry, -1 on delivery, internal moves net zero.
    always_comb begin
        occ_d   = occ_q;
        done_d  = done_q;
        stall_d = stall_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(stage_en[ST_PPGEN]) - OCC_W'(adv[STAGES-1]);
            if (adv[STAGES-1]) done_d = done_q + CNT_W'(1);
        end
        if (v[STAGES-1] & ~hs.out_ready) stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q   <= '0;
            done_q  <= '0;
            stall_q <= '0;
        end else begin
            occ_q   <= occ_d;
            done_q  <= done_d;
            stall_q <= stall_d;
        end
    end

    assign hs.in_ready    = in_ready;
    assign hs.out_valid   = v[STAGES-1];
    assign hs.out_tag     = tag[STAGES-1];
    assign hs.out_special = spec[STAGES-1];
    assign busy           = |v;
    assign occupancy      = occ_q;
    assign done_cnt       = done_q;
    assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_fpm_pipe_ctrl.sv
// Directed bench for fpm_pipe_ctrl: an occupancy-list model checked every cycle,
// plus literal expectations for latency, ordering, backpressure, bubbles, flush and reset.
module tb_fpm_pipe_ctrl;
    import fpm_pkg::*;

    localparam int S  = 4;
    localparam int TW = 4;
    localparam int CW = 16;
    localparam int OW = $clog2(S + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [S-1:0]  stage_en;
    logic          busy;
    logic [OW-1:0] occupancy;
    logic [CW-1:0] done_cnt;
    logic [CW-1:0] stall_cnt;

    fpm_pipe_ctrl_if #(.TAG_W(TW)) hs ();

    fpm_pipe_ctrl #(.STAGES(S), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hs        (hs),
        .flush     (flush),
        .stage_en  (stage_en),
        .busy      (busy),
        .occupancy (occupancy),
        .done_cnt  (done_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: slot list of operations; an op moves on if anything downstream of it is empty
    // or the consumer is ready; the pipeline accepts unless every slot is full and stalled.
    logic          m_ok = 1'b0;
    logic [S-1:0]  mv, ms;
    fpm_tag_t      mt [S];
    logic [CW-1:0] m_done, m_stall;
    fpm_tag_t      dlog [$];
    int            dcyc [$];
    int            cyc = 0;

    always @(negedge clk) begin
        logic         any_empty, e_in_ready, free_down;
        logic [S-1:0] e_adv, e_en, nv, ns;
        fpm_tag_t     nt [S];
        int           e_occ;
        cyc++;
        e_occ = 0;
        any_empty = 1'b0;
        for (int j = 0; j < S; j++) begin
            if (mv[j]) e_occ++;
            else any_empty = 1'b1;
        end
        e_in_ready = rst_n && !flush && (hs.out_ready || any_empty);
        for (int j = 0; j < S; j++) begin
            free_down = hs.out_ready;
            for (int k = j + 1; k < S; k++) if (!mv[k]) free_down = 1'b1;
            e_adv[j] = mv[j] && free_down;
        end
        e_en = '0;
        e_en[0] = hs.in_valid && e_in_ready;
        for (int i = 1; i < S; i++) e_en[i] = rst_n && !flush && e_adv[i-1];

        if (m_ok) begin
            check("cmp_out_valid", 32'(hs.out_valid), 32'(mv[S-1]));
            if (mv[S-1]) begin
                check("cmp_out_tag", 32'(hs.out_tag), 32'(mt[S-1]));
                check("cmp_out_special", 32'(hs.out_special), 32'(ms[S-1]));
            end
            check("cmp_busy", 32'(busy), 32'(e_occ != 0));
            check("cmp_occupancy", 32'(occupancy), 32'(e_occ));
            check("cmp_in_ready", 32'(hs.in_ready), 32'(e_in_ready));
            check("cmp_stage_en", 32'(stage_en), 32'(e_en));
            check("cmp_done_cnt", 32'(done_cnt), 32'(m_done));
            check("cmp_stall_cnt", 32'(stall_cnt), 32'(m_stall));
        end

        if (rst_n && !flush && hs.out_valid && hs.out_ready) begin
            dlog.push_back(hs.out_tag);
            dcyc.push_back(cyc);
        end

        if (!rst_n) begin
            mv = '0; ms = '0; m_done = '0; m_stall = '0;
            for (int j = 0; j < S; j++) mt[j] = '0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            if (mv[S-1] && !hs.out_ready) m_stall = m_stall + 1'b1;
            nv = '0; ns = ms;
            for (int j = 0; j < S; j++) nt[j] = mt[j];
            if (!flush) begin
                for (int j = 0; j < S; j++) begin
                    if (mv[j] && !e_adv[j]) begin
                        nv[j] = 1'b1; nt[j] = mt[j]; ns[j] = ms[j];
                    end else if (mv[j] && j < S - 1) begin
                        nv[j+1] = 1'b1; nt[j+1] = mt[j]; ns[j+1] = ms[j];
                    end else if (mv[j]) begin
                        m_done = m_done + 1'b1;
                    end
                end
                if (e_en[0]) begin
                    nv[0] = 1'b1; nt[0] = hs.in_tag; ns[0] = hs.in_special;
                end
            end
            mv = nv; ms = ns;
            for (int j = 0; j < S; j++) mt[j] = nt[j];
        end
    end

    task automatic wait_deliv(input int target, input string name);
        int k = 0;
        while (dlog.size() < target && k < 40) begin
            @(negedge clk);
            step();
            k++;
        end
        check(name, 32'(dlog.size()), 32'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [S-1:0] en_tr [4];
        int lat, base, peak, idx;
        logic [CW-1:0] s0, d0;

        rst_n = 1'b0; flush = 1'b0;
        hs.in_valid = 1'b0; hs.in_tag = '0; hs.in_special = 1'b0; hs.out_ready = 1'b0;
        step(); step();
        @(negedge clk);
        check("reset_in_ready_low", 32'(hs.in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_occupancy", 32'(occupancy), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(hs.out_valid), 32'd0);
        check("reset_in_ready_after", 32'(hs.in_ready), 32'd1);

        // Single operation: latency and one-hot enable walk.
        step();
        hs.out_ready = 1'b1; hs.in_valid = 1'b1; hs.in_tag = 4'd3; hs.in_special = 1'b0;
        @(negedge clk);
        check("single_en0", 32'(stage_en), 32'b0001);
        step();
        hs.in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 3) en_tr[k] = stage_en;
            if (hs.out_valid) begin
                lat = k;
                break;
            end
            step();
        end
        check("single_latency", 32'(lat), 32'd4);
        check("single_en1", 32'(en_tr[1]), 32'b0010);
        check("single_en2", 32'(en_tr[2]), 32'b0100);
        check("single_en3", 32'(en_tr[3]), 32'b1000);
        check("single_tag", 32'(hs.out_tag), 32'd3);
        step();
        @(negedge clk);
        check("single_done", 32'(done_cnt), 32'd1);

        // Ten back-to-back operations.
        step();
        base = dlog.size(); peak = 0;
        hs.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            hs.in_tag = 4'(i); hs.in_special = i[0];
            @(negedge clk);
            if (int'(occupancy) > peak) peak = int'(occupancy);
            step();
        end
        hs.in_valid = 1'b0;
        wait_deliv(base + 10, "b2b_count");
        for (int i = 0; i < 10; i++) check("b2b_order", 32'(dlog[base+i]), 32'(i));
        check("b2b_consecutive", 32'(dcyc[base+9] - dcyc[base]), 32'd9);
        check("b2b_peak_occ", 32'(peak), 32'd4);

        // Backpressure: six ops against a stalled consumer.
        step();
        base = dlog.size(); idx = 0;
        hs.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            hs.in_valid = (idx < 6); hs.in_tag = 4'(10 + idx); hs.in_special = 1'b0;
            @(negedge clk);
            if (hs.in_ready) idx++;
            step();
        end
        @(negedge clk);
        check("bp_accepted", 32'(idx), 32'd4);
        check("bp_in_ready", 32'(hs.in_ready), 32'd0);
        check("bp_occupancy", 32'(occupancy), 32'd4);
        check("bp_head_tag", 32'(hs.out_tag), 32'd10);
        s0 = stall_cnt;
        step(); step(); step();
        @(negedge clk);
        check("bp_stall_cnt", 32'(stall_cnt), 32'(s0 + 16'd3));
        step();
        hs.out_ready = 1'b1;
        for (int k = 0; k < 10 && idx < 6; k++) begin
            hs.in_valid = 1'b1; hs.in_tag = 4'(10 + idx);
            @(negedge clk);
            if (hs.in_ready) idx++;
            step();
        end
        hs.in_valid = 1'b0;
        check("bp_all_accepted", 32'(idx), 32'd6);
        wait_deliv(base + 6, "bp_count");
        for (int i = 0; i < 6; i++) check("bp_order", 32'(dlog[base+i]), 32'(10 + i));

        // Bubble collapse behind a stalled head.
        step();
        base = dlog.size();
        hs.out_ready = 1'b0; hs.in_valid = 1'b1; hs.in_tag = 4'd1; hs.in_special = 1'b1;
        step();
        hs.in_valid = 1'b0;
        step(); step();
        hs.in_valid = 1'b1; hs.in_tag = 4'd2; hs.in_special = 1'b0;
        step();
        hs.in_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("bubble_occupancy", 32'(occupancy), 32'd2);
        check("bubble_stage_en", 32'(stage_en), 32'd0);
        check("bubble_head_tag", 32'(hs.out_tag), 32'd1);
        check("bubble_head_special", 32'(hs.out_special), 32'd1);
        check("bubble_in_ready", 32'(hs.in_ready), 32'd1);
        step();
        hs.out_ready = 1'b1;
        wait_deliv(base + 2, "bubble_count");
        check("bubble_order_a", 32'(dlog[base]), 32'd1);
        check("bubble_order_b", 32'(dlog[base+1]), 32'd2);

        // Flush with three in flight and a competing input.
        step();
        hs.out_ready = 1'b0; hs.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hs.in_tag = 4'(4 + i);
            step();
        end
        hs.in_valid = 1'b0;
        step();
        @(negedge clk);
        check("flush_pre_occ", 32'(occupancy), 32'd3);
        check("flush_pre_out_valid", 32'(hs.out_valid), 32'd1);
        d0 = done_cnt;
        base = dlog.size();
        step();
        flush = 1'b1; hs.in_valid = 1'b1; hs.in_tag = 4'd7; hs.out_ready = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(hs.in_ready), 32'd0);
        check("flush_stage_en", 32'(stage_en), 32'd0);
        step();
        flush = 1'b0; hs.in_valid = 1'b0;
        @(negedge clk);
        check("flush_occupancy", 32'(occupancy), 32'd0);
        check("flush_out_valid", 32'(hs.out_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done_held", 32'(done_cnt), 32'(d0));
        repeat (4) step();
        @(negedge clk);
        check("flush_no_late_occ", 32'(occupancy), 32'd0);
        check("flush_no_delivery", 32'(dlog.size()), 32'(base));

        // Reset with the pipeline full.
        step();
        hs.out_ready = 1'b0; hs.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            hs.in_tag = 4'(8 + i);
            step();
        end
        hs.in_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_occ", 32'(occupancy), 32'd4);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_ready_low", 32'(hs.in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(hs.out_valid), 32'd0);
        check("rst_out_tag", 32'(hs.out_tag), 32'd0);
        check("rst_done", 32'(done_cnt), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_stage_en", 32'(stage_en), 32'd0);
        check("rst_in_ready_after", 32'(hs.in_ready), 32'd1);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpm_pipe_ctrl.md
# fpm_pipe_ctrl

Elastic pipeline controller for the radix-4 floating-point multiplier datapath (Booth partial-product generation, reduction tree stages, final carry-propagate add, normalize/round). It owns per-stage valid, tag and special-case bits. It drives per-stage register load enables to the datapath and implements valid/ready handshakes on both ends with full backpressure. It also collapses bubbles, supports a synchronous flush, and keeps occupancy and performance counters.

## Interface
- `STAGES`, default 4: number of datapath register stages sequenced; legal range 2–8.
- `TAG_W`, default 4: width of the requester tag carried alongside each operation.
- `CNT_W`, default 16: width of the performance counters.

- `clk`  in  1  clock. All logic is rising-edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `in_valid`  in  1  operand pair presented to stage 0.
- `in_ready`  out  1  stage 0 can load this cycle.
- `in_tag`  in  TAG_W  tag of the presented operation.
- `in_special`  in  1  operands are NaN, Inf or zero; the datapath result is overridden at the output.
- `stage_en`  out  STAGES  load enable for datapath stage i registers.
- `out_valid`  out  1  last stage holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `out_tag`  out  TAG_W  tag of the result at the last stage.
- `out_special`  out  1  special bit of the result at the last stage.
- `flush`  in  1  discard all in-flight operations.
- `busy`  out  1  any stage valid.
- `occupancy`  out  $clog2(STAGES+1)  number of valid stages.
- `done_cnt`  out  CNT_W  results delivered (out_valid & out_ready), wrapping.
- `stall_cnt`  out  CNT_W  cycles with out_valid & !out_ready, wrapping.

## Operation
- Per-stage state: `v[i]`, `tag[i]`, `spec[i]`. Stage STAGES-1 is the output stage.
- Stage advance rule:
  - `adv[STAGES-1] = v[STAGES-1] & out_ready`.
  - Stage i can load when `ld_ok[i] = !v[i] | adv[i]`.
  - `adv[i] = v[i] & ld_ok[i+1]` for i < STAGES-1.
- `in_ready = ld_ok[0] & !flush`.
- Enables:
  - `stage_en[0] = in_valid & in_ready`.
  - `stage_en[i] = adv[i-1] & !flush` for i ≥ 1.
  - A stage whose enable is low holds its datapath registers. Enables are never asserted on bubbles.
- On a stage_en edge, `v[i]`, `tag[i]` and `spec[i]` take the upstream values. If the stage advances without a reload, `v[i]` clears.
- Bubbles collapse: a valid stage moves into an empty downstream stage even while the output is stalled.
- Flush has priority over everything in its cycle:
  - All `v` clear at the edge.
  - `stage_en = 0`, `in_ready = 0`.
  - `done_cnt` does not increment even if out_ready is high.
- `occupancy` is the popcount of `v`, registered, consistent with `v` in the same cycle. `busy = |v`.
- `out_valid`, `out_tag` and `out_special` are stable while out_valid & !out_ready.
- Counters wrap modulo 2^CNT_W. The stall count saturates never.
- In-flight operations complete in issue order; there is no reordering.

## Timing
- Reset values (rst_n low at an edge): all `v = 0`, `tag = 0`, `spec = 0`, counters `0`. This gives `out_valid = 0`, `busy = 0`, `occupancy = 0`, `stage_en = 0`.
- During reset, `in_ready` is driven 0.
- Latency: an operation accepted at edge T has `out_valid` high in the cycle after edge T+STAGES-1, i.e. STAGES cycles, with no stalls.
- Throughput: 1 per cycle with out_ready held high.
- Full pipeline with `out_ready = 0`: `in_ready = 0`. The same-cycle rise of out_ready makes in_ready 1 combinationally; the ready path chains through all stages.
- Reset mid-operation discards in-flight data with no output and no counter increment.

## Structure
- Package `fpm_pkg`: `FPM_STAGES` default, `fpm_tag_t`, the stage index constants (`ST_PPGEN`, `ST_RED`, `ST_CPA`, `ST_NORM`), and the counter width.
- Sub-module `fpm_stage_slot`: one v/tag/spec register with its load/advance/flush logic, instantiated STAGES times. Ready chaining and the counters stay in the top.

## Test plan
- Single op, tag 3, special 0, with out_ready = 1:
  - out_valid rises exactly 4 cycles after acceptance, out_tag = 3.
  - done_cnt = 1.
  - stage_en walks one-hot 0001→1000.
- 10 back-to-back ops with tags 0–9 and out_ready = 1: results arrive on 10 consecutive cycles in order 0–9; occupancy peaks at 4.
- Backpressure:
  - Issue 6 ops with out_ready = 0: after 4 accepted, in_ready = 0 and occupancy = 4.
  - stall_cnt increments each cycle out_valid is held.
  - Release out_ready: the remaining 2 ops are accepted, and all 6 are delivered in order.
- Bubble collapse: issue op A, idle 2 cycles, issue op B, hold out_ready = 0. B advances until adjacent to A; occupancy = 2 and stage_en is 0 for full stages.
- Flush with 3 in flight and in_valid = 1 in the same cycle:
  - Next cycle occupancy = 0, out_valid = 0.
  - The flush-cycle input is not accepted; done_cnt is unchanged.
- rst_n low for 1 cycle with the pipeline full:
  - All outputs return to reset values.
  - in_ready = 0 during reset and 1 in the cycle after.
